rgb_frame_packer: RTL and testbench
===================================

Name: rgb_frame_packer

Overview:
- Write-side counterpart to the image hex loader, which unpacks interleaved R,G,B bytes into separate pixel components. This block does the reverse.
- Accepts a raster-order pixel stream (row 0 first, left to right) over a valid/ready handshake.
- Writes each pixel as three interleaved bytes (R, G, B) into a byte-wide frame buffer, using the same bottom-up row layout as the hex image files, so the buffer can be dumped straight to an output .hex.

Parameters:
- HEIGHT, 256, image rows
- WIDTH, 256, image columns
- ADDR_W, 18, byte address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT*3

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a frame; honoured only in IDLE
- in_valid  input  1  pixel present on in_r/in_g/in_b
- in_ready  output  1  block can accept a pixel this cycle
- in_r  input  8  red component
- in_g  input  8  green component
- in_b  input  8  blue component
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_W  byte address
- mem_wdata  output  8  byte data
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse after the last byte of a frame is written

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0; row/col counters=0; pixel latch=0.
- All outputs are registered except in_ready, which is decoded from state (in_ready=1 only in WAIT).
- States: IDLE, WAIT, WR_R, WR_G, WR_B, DONE.
- IDLE: start=1 -> WAIT; row=0, col=0. in_valid is ignored here.
- WAIT: when in_valid & in_ready, latch r,g,b and go to WR_R. Otherwise stay.
- WR_R: mem_we=1, mem_addr=base+0, mem_wdata=r.
- WR_G: mem_we=1, mem_addr=base+1, mem_wdata=g.
- WR_B: mem_we=1, mem_addr=base+2, mem_wdata=b.
- The mem_* values listed for a state appear in the cycle the state is occupied. mem_we=0 in all other states.
- base = WIDTH*3*(HEIGHT-1-row) + 3*col. Compute it incrementally (row base register plus column offset); no multiplier in the datapath.
- After WR_B:
  - if col==WIDTH-1 and row==HEIGHT-1 -> DONE;
  - else advance: col+1, or col=0 and row+1 at the end of a row; then -> WAIT.
- Counter widths hold the full range with no wrap. WIDTH=1 and HEIGHT=1 must both work.
- DONE: frame_done=1 for exactly this one cycle -> IDLE. busy=0 from IDLE onward.
- Throughput: 4 cycles per pixel minimum. Latency: handshake cycle N -> R byte written in cycle N+1, G in N+2, B in N+3.
- Backpressure: in_valid low in WAIT stalls indefinitely with no writes. Pixel data change while not handshaking has no effect.
- start asserted while busy is ignored; it neither restarts nor corrupts the frame.
- start and the final WR_B in the same cycle: start is ignored (the block is busy).
- Reset mid-frame: immediate return to IDLE. The partially written buffer is left as-is, and no frame_done is issued.
- No address outside 0..WIDTH*HEIGHT*3-1 is ever written.

Test Plan:
- WIDTH=4, HEIGHT=2; start, first pixel (0x11,0x22,0x33) -> writes addr 12=0x11, 13=0x22, 14=0x33 on 3 consecutive cycles, starting 1 cycle after the handshake.
- Same config, full frame of 8 pixels with in_valid held high -> last pixel (row1, col3) written to addr 9,10,11; frame_done high exactly 1 cycle after the addr-11 write; busy=0 the cycle after; exactly 24 writes total, each address 0..23 written once.
- in_valid toggled randomly, in_r/in_g/in_b changed while in_valid=0 -> buffer contents match the reference bottom-up layout; no mem_we during stall cycles; in_ready=1 only in WAIT.
- start pulsed mid-frame and again on the final WR_B cycle -> no restart; write sequence and frame_done timing identical to an undisturbed frame.
- rst asserted asynchronously (between clock edges) after 3 pixels -> all outputs 0 immediately; no frame_done; a new start then writes from addr 12 again.
- WIDTH=1, HEIGHT=1 -> single pixel written to addr 0,1,2, then frame_done.

Source files
------------

// File: rtl/rgb_frame_packer.sv
`timescale 1ns/1ps
// rgb_frame_packer
//   Takes a raster-order pixel stream (row 0 first, left to right) over a
//   valid/ready handshake. Each pixel is written as three interleaved bytes
//   (R, G, B) into a byte-wide frame buffer. Rows are stored bottom-up, so the
//   buffer matches the hex image file layout and can be dumped directly.
//
//   Handshake: a pixel transfers on a rising edge where in_valid and in_ready
//   are both high. in_ready is high only while waiting for a pixel. The
//   producer may hold in_valid high indefinitely, and pixel data has no effect
//   on cycles without a transfer.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle frame request, honoured only when idle
//   in_valid/in_ready pixel handshake
//   in_r/in_g/in_b    pixel components
//   mem_we/mem_addr/mem_wdata  registered byte write port
//   busy              high in every state except IDLE
//   frame_done        one-cycle pulse after the last byte of a frame
module rgb_frame_packer #(
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR_R,
    S_WR_G,
    S_WR_B,
    S_DONE
  } state_t;

  // Counter widths stay at least one bit so WIDTH=1 / HEIGHT=1 elaborate.
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  // Both constants are folded at elaboration; the datapath only adds/subtracts.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH * 3);
  localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'(WIDTH * 3 * (HEIGHT - 1));

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;   // WIDTH*3*(HEIGHT-1-row)
  logic [ADDR_W-1:0] col_off_q, col_off_d;     // 3*col
  logic [7:0]        g_q, g_d;
  logic [7:0]        b_q, b_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  // Registered outputs are computed on entry to a state, so the write values
  // for WR_R/WR_G/WR_B are visible during the cycle that state is occupied.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    col_off_d    = col_off_q;
    g_d          = g_q;
    b_d          = b_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = S_WAIT;
          busy_d     = 1'b1;
          col_d      = '0;
          row_d      = '0;
          row_base_d = TOP_BASE;
          col_off_d  = '0;
        end
      end

      S_WAIT: begin
        if (in_valid) begin
          // Red goes straight into the write-data register; green and blue
          // are held for the following two cycles.
          state_d     = S_WR_R;
          mem_we_d    = 1'b1;
          mem_addr_d  = row_base_q + col_off_q;
          mem_wdata_d = in_r;
          g_d         = in_g;
          b_d         = in_b;
        end
      end

      S_WR_R: begin
        state_d     = S_WR_G;
        mem_we_d    = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        mem_wdata_d = g_q;
      end

      S_WR_G: begin
        state_d     = S_WR_B;
        mem_we_d    = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        mem_wdata_d = b_q;
      end

      S_WR_B: begin
        if (col_q == COL_LAST && row_q == ROW_LAST) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          if (col_q == COL_LAST) begin
            col_d      = '0;
            col_off_d  = '0;
            row_d      = row_q + ROW_W'(1);
            row_base_d = row_base_q - ROW_STEP;
          end else begin
            col_d     = col_q + COL_W'(1);
            col_off_d = col_off_q + ADDR_W'(3);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      col_off_q    <= '0;
      g_q          <= '0;
      b_q          <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      col_off_q    <= col_off_d;
      g_q          <= g_d;
      b_q          <= b_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = (state_q == S_WAIT);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_frame_packer.sv
`timescale 1ns/1ps
// Bench for rgb_frame_packer: a 4x2 instance exercised over several frames
// (held valid, random stalls, stray start pulses, mid-frame reset) and a 1x1
// instance for the degenerate frame size.
module tb_rgb_frame_packer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 18;
  localparam int NB = W * H * 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4x2 DUT ----------------
  logic          start = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0]    in_r = '0, in_g = '0, in_b = '0;
  logic          mem_we, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  rgb_frame_packer #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done)
  );

  // ---------------- 1x1 DUT ----------------
  logic          s_start = 1'b0, s_valid = 1'b0, s_ready;
  logic [7:0]    s_r = '0, s_g = '0, s_b = '0;
  logic          s_we, s_busy, s_done;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_wdata;

  rgb_frame_packer #(.HEIGHT(1), .WIDTH(1), .ADDR_W(AW)) dut_1x1 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_r(s_r), .in_g(s_g), .in_b(s_b), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .busy(s_busy), .frame_done(s_done)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: {cycle[31:0], 6'b0, addr[17:0], data[7:0]}
  logic [63:0] exp_q[$];
  logic [7:0]  mem_model [0:NB-1];
  logic [7:0]  ref_mem   [0:NB-1];
  int          wcount    [0:NB-1];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_b   = 0;
  logic        done_prev = 1'b0;
  logic [63:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) chk("spurious_we", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", cyc, mon_e[63:32]);
          chk("wr_addr", mem_addr, mon_e[25:8]);
          chk("wr_data", mem_wdata, mon_e[7:0]);
          if (mem_addr < NB) begin
            wcount[mem_addr]++;
            mem_model[mem_addr] = mem_wdata;
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_prev) chk("post_done_idle", {frame_done, busy, in_ready}, 3'b000);
      if (in_ready) chk("ready_only_in_wait", {mem_we, frame_done, busy}, 3'b001);
    end
    done_prev = frame_done & ~rst;
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic push_exp(input int c, input int a, input logic [7:0] d);
    exp_q.push_back({32'(c), 6'd0, 18'(a), d});
    ref_mem[a] = d;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int idle, input int row, input int col);
    int n;
    int a;
    for (int i = 0; i < idle; i++) begin
      in_valid = 1'b0;
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_r = r; in_g = g; in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("handshake_timeout", in_ready, 1);
    else begin
      @(posedge clk); #1;
      a = W * 3 * (H - 1 - row) + 3 * col;
      push_exp(cyc, a, r);
      push_exp(cyc + 1, a + 1, g);
      push_exp(cyc + 2, a + 2, b);
      last_b = cyc + 2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit stall, input bit poke);
    int d0;
    int n;
    logic [7:0] r, g, b;
    for (int a = 0; a < NB; a++) begin
      wcount[a] = 0; mem_model[a] = 8'h00; ref_mem[a] = 8'h00;
    end
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < W * H; k++) begin
      if (k == 0 && !stall) begin
        r = 8'h11; g = 8'h22; b = 8'h33;
      end else begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end
      if (poke && k == 4) pulse_start();
      send_pixel(r, g, b, stall ? $urandom_range(0, 3) : 0, k / W, k % W);
      if (poke && k == W * H - 1) begin
        @(posedge clk); #1;          // WR_G
        @(posedge clk); #1;          // WR_B: start sampled on the closing edge
        pulse_start();
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    chk("done_timing", done_cyc, last_b + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart_busy", busy, 0);
    chk("done_once", done_cnt, d0 + 1);
    chk("exp_q_empty", exp_q.size(), 0);
    for (int a = 0; a < NB; a++) begin
      chk("write_count", wcount[a], 1);
      chk("buffer_data", mem_model[a], ref_mem[a]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int n;
    #2;
    chk("reset_state", {in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done}, '0);
    chk("reset_state_1x1", {s_ready, s_we, s_addr, s_wdata, s_busy, s_done}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_not_ready", {in_ready, busy}, 2'b00);

    // Full frame, in_valid held high, first pixel 11/22/33 -> addr 12..14.
    run_frame(1'b0, 1'b0);
    // Random stalls with data churn while in_valid is low.
    run_frame(1'b1, 1'b0);
    // Stray start pulses mid-frame and on the final WR_B cycle.
    run_frame(1'b1, 1'b1);

    // Asynchronous reset after three pixels.
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 3; k++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, k);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_reset", in_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, d0);
    chk("reset_exp_q_empty", exp_q.size(), 0);
    chk("idle_after_reset", busy, 0);
    // New frame restarts from the top-row base (addr 12).
    run_frame(1'b0, 1'b0);

    // 1x1 frame: bytes at 0,1,2 then frame_done.
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_r = 8'hA5; s_g = 8'h5A; s_b = 8'hC3; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_r = 8'h00; s_g = 8'h00; s_b = 8'h00;
    chk("s_wr_r", {s_we, s_addr, s_wdata, s_done}, {1'b1, 18'd0, 8'hA5, 1'b0});
    @(posedge clk); #1;
    chk("s_wr_g", {s_we, s_addr, s_wdata, s_done}, {1'b1, 18'd1, 8'h5A, 1'b0});
    @(posedge clk); #1;
    chk("s_wr_b", {s_we, s_addr, s_wdata, s_done}, {1'b1, 18'd2, 8'hC3, 1'b0});
    @(posedge clk); #1;
    chk("s_done", {s_we, s_done, s_busy}, 3'b011);
    @(posedge clk); #1;
    chk("s_idle", {s_we, s_done, s_busy, s_ready}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
